// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-PC source encoding.
package pc_pkg;

  localparam int unsigned PC_SRC_W = 3;

  // Codes 6 and 7 are reserved and behave like ALU.
  typedef enum logic [PC_SRC_W-1:0] {
    INC    = 3'd0,
    BRANCH = 3'd1,
    JUMP   = 3'd2,
    ALU    = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5
  } pc_src_t;

endpackage

// File: rtl/pc_unit_ras_if.sv
// Control/status bundle between the control FSM and pc_unit_ras.
// Optional PC_PREV_EN adds the pc_prev status signal.
interface pc_unit_ras_if #(
  parameter int unsigned ADDR_W = 32
);

  logic                         pc_write;
  logic                         pc_write_cond;
  logic                         zero;
  logic [pc_pkg::PC_SRC_W-1:0]  pc_source;
  logic [ADDR_W-1:0]            jump_address;
  logic [ADDR_W-1:0]            alu_out_result;
  logic [ADDR_W-1:0]            alu_result;
  logic                         clr_err;
  logic [ADDR_W-1:0]            pc_out;
  logic                         ras_full;
  logic                         ras_empty;
  logic                         ras_overflow;
  logic                         ras_underflow;
`ifdef PC_PREV_EN
  logic [ADDR_W-1:0]            pc_prev;
`endif

  modport master (
    output pc_write, pc_write_cond, zero, pc_source, jump_address, alu_out_result, alu_result,
           clr_err,
    input  pc_out, ras_full, ras_empty, ras_overflow, ras_underflow
`ifdef PC_PREV_EN
    , input pc_prev
`endif
  );

  modport slave (
    input  pc_write, pc_write_cond, zero, pc_source, jump_address, alu_out_result, alu_result,
           clr_err,
    output pc_out, ras_full, ras_empty, ras_overflow, ras_underflow
`ifdef PC_PREV_EN
    , output pc_prev
`endif
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty,
  output logic         ovf_pulse,
  output logic         unf_pulse
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] top_q, top_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];

  assign full      = (cnt_q == CntW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign top_data  = mem_q[top_q];
  assign ovf_pulse = push & full;
  assign unf_pulse = pop & empty;

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (push) begin
      // Pointer wraps naturally because DEPTH is a power of two.
      top_d        = top_q + PtrW'(1);
      mem_d[top_d] = push_data;
      if (!full) cnt_d = cnt_q + CntW'(1);
    end else if (pop && !empty) begin
      top_d = top_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage is not reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit with next-PC mux, conditional write and CALL/RET return stack.
// Optional PC_PREV_EN adds the pc_prev register (previous PC for exceptions).
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] STEP      = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  pc_unit_ras_if.slave bus
);

  logic              en;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] top_data;
  logic              ras_full;
  logic              ras_empty;
  logic              ovf_pulse;
  logic              unf_pulse;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (top_data),
    .full      (ras_full),
    .empty     (ras_empty),
    .ovf_pulse (ovf_pulse),
    .unf_pulse (unf_pulse)
  );

  always_comb begin
    en     = bus.pc_write | (bus.pc_write_cond & bus.zero);
    pc_inc = pc_q + STEP;
    push   = en && (bus.pc_source == CALL);
    pop    = en && (bus.pc_source == RET);
    pc_d   = pc_q;
    if (en) begin
      case (bus.pc_source)
        INC:     pc_d = pc_inc;
        BRANCH:  pc_d = bus.alu_out_result;
        JUMP:    pc_d = bus.jump_address;
        ALU:     pc_d = bus.alu_result;
        CALL:    pc_d = bus.jump_address;
        // Return on an empty stack falls through to the next sequential address.
        RET:     pc_d = ras_empty ? pc_inc : top_data;
        default: pc_d = bus.alu_result;
      endcase
    end
    // A flag raised on the same edge as a clear stays set.
    ovf_d = (ovf_q & ~bus.clr_err) | ovf_pulse;
    unf_d = (unf_q & ~bus.clr_err) | unf_pulse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

`ifdef PC_PREV_EN
  logic [ADDR_W-1:0] pc_prev_q, pc_prev_d;

  always_comb begin
    pc_prev_d = en ? pc_q : pc_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_prev_q <= RESET_VEC;
    end else begin
      pc_prev_q <= pc_prev_d;
    end
  end

  assign bus.pc_prev = pc_prev_q;
`endif

  assign bus.pc_out        = pc_q;
  assign bus.ras_full      = ras_full;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: directed scenarios plus randomized traffic vs a queue model.
module tb_pc_unit_ras;
  import pc_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] prev;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_unit_ras_if #(.ADDR_W(AW)) bus ();

  pc_unit_ras #(
    .ADDR_W    (AW),
    .STEP      (32'd1),
    .RESET_VEC (32'd0),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t          exp_q[$];
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_prev;
  logic [AW-1:0] m_ras[$];
  bit            m_ovf;
  bit            m_unf;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = '0;
    m_prev = '0;
    m_ras.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic drive_idle();
    bus.pc_write       = 1'b0;
    bus.pc_write_cond  = 1'b0;
    bus.zero           = 1'b0;
    bus.pc_source      = '0;
    bus.jump_address   = '0;
    bus.alu_out_result = '0;
    bus.alu_result     = '0;
    bus.clr_err        = 1'b0;
  endtask

  // Drive one cycle of inputs and queue the state expected after the next rising edge.
  task automatic step(input bit pw, input bit pwc, input bit z, input logic [2:0] src,
                      input logic [AW-1:0] ja, input logic [AW-1:0] aor,
                      input logic [AW-1:0] ar, input bit clr);
    exp_t e;
    bit   en;
    bit   os;
    bit   us;
    @(negedge clk);
    bus.pc_write       = pw;
    bus.pc_write_cond  = pwc;
    bus.zero           = z;
    bus.pc_source      = src;
    bus.jump_address   = ja;
    bus.alu_out_result = aor;
    bus.alu_result     = ar;
    bus.clr_err        = clr;
    en = pw || (pwc && z);
    os = 1'b0;
    us = 1'b0;
    if (en) begin
      m_prev = m_pc;
      case (src)
        3'd0: m_pc = m_pc + 32'd1;
        3'd1: m_pc = aor;
        3'd2: m_pc = ja;
        3'd3: m_pc = ar;
        3'd4: begin
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            os = 1'b1;
          end
          m_ras.push_back(m_pc + 32'd1);
          m_pc = ja;
        end
        3'd5: begin
          if (m_ras.size() == 0) begin
            m_pc = m_pc + 32'd1;
            us   = 1'b1;
          end else begin
            m_pc = m_ras.pop_back();
          end
        end
        default: m_pc = ar;
      endcase
    end
    m_ovf   = (m_ovf && !clr) || os;
    m_unf   = (m_unf && !clr) || us;
    e.pc    = m_pc;
    e.prev  = m_prev;
    e.full  = (m_ras.size() == DEPTH);
    e.empty = (m_ras.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every cycle that has an expectation queued.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out", bus.pc_out, e.pc);
        chk("ras_full", 32'(bus.ras_full), 32'(e.full));
        chk("ras_empty", 32'(bus.ras_empty), 32'(e.empty));
        chk("ras_overflow", 32'(bus.ras_overflow), 32'(e.ovf));
        chk("ras_underflow", 32'(bus.ras_underflow), 32'(e.unf));
`ifdef PC_PREV_EN
        chk("pc_prev", bus.pc_prev, e.prev);
`endif
      end
    end
  end

  initial begin : stim
    logic [2:0]    src;
    logic [AW-1:0] ja;
    int            r;
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc_out", bus.pc_out, 32'h0);
    chk("reset ras_empty", 32'(bus.ras_empty), 32'd1);
    chk("reset ras_full", 32'(bus.ras_full), 32'd0);
    chk("reset ras_overflow", 32'(bus.ras_overflow), 32'd0);
    chk("reset ras_underflow", 32'(bus.ras_underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, INC, '0, '0, '0, 0);
      settle();
      chk("inc pc_out", bus.pc_out, 32'(i));
    end
    chk("inc ras_empty", 32'(bus.ras_empty), 32'd1);

    // Conditional branch
    step(0, 1, 0, BRANCH, '0, 32'h40, '0, 0);
    settle();
    chk("cond zero=0 holds", bus.pc_out, 32'h3);
    step(0, 1, 1, BRANCH, '0, 32'h40, '0, 0);
    settle();
    chk("cond zero=1 branch", bus.pc_out, 32'h40);

    // Nested call/return
    step(1, 0, 0, JUMP, 32'h10, '0, '0, 0);
    step(1, 0, 0, CALL, 32'h100, '0, '0, 0);
    settle();
    chk("call1", bus.pc_out, 32'h100);
    step(1, 0, 0, CALL, 32'h200, '0, '0, 0);
    settle();
    chk("call2", bus.pc_out, 32'h200);
    step(1, 0, 0, RET, '0, '0, '0, 0);
    settle();
    chk("ret1", bus.pc_out, 32'h101);
    step(1, 0, 0, RET, '0, '0, '0, 0);
    settle();
    chk("ret2", bus.pc_out, 32'h11);
    chk("nest empty", 32'(bus.ras_empty), 32'd1);

    // Overflow: five calls into a four-deep stack
    step(1, 0, 0, JUMP, 32'h0, '0, '0, 0);
    for (int i = 1; i <= 5; i++) step(1, 0, 0, CALL, 32'(i), '0, '0, 0);
    settle();
    chk("ovf full", 32'(bus.ras_full), 32'd1);
    chk("ovf flag", 32'(bus.ras_overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, RET, '0, '0, '0, 0);
      settle();
      chk("ovf ret", bus.pc_out, 32'(5 - i));
    end
    chk("ovf drained empty", 32'(bus.ras_empty), 32'd1);

    // Underflow and sticky clear
    step(1, 0, 0, JUMP, 32'h20, '0, '0, 0);
    step(1, 0, 0, RET, '0, '0, '0, 0);
    settle();
    chk("unf fallthrough", bus.pc_out, 32'h21);
    chk("unf flag", 32'(bus.ras_underflow), 32'd1);
    step(0, 0, 0, INC, '0, '0, '0, 1);
    settle();
    chk("unf cleared", 32'(bus.ras_underflow), 32'd0);
    chk("ovf cleared", 32'(bus.ras_overflow), 32'd0);
    step(1, 0, 0, RET, '0, '0, '0, 1);
    settle();
    chk("unf set beats clear", 32'(bus.ras_underflow), 32'd1);

    // Suppressed call has no stack effect
    step(0, 1, 0, CALL, 32'h77, '0, '0, 0);
    settle();
    chk("suppressed call empty", 32'(bus.ras_empty), 32'd1);

    // Randomized traffic, with all-ones targets to exercise wrap
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 9);
      src = (r < 3) ? 3'd4 : (r < 6) ? 3'd5 : 3'($urandom_range(0, 7));
      ja  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           src, ja, $urandom, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
           $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset between edges with live stack entries
    step(1, 0, 0, JUMP, 32'h50, '0, '0, 0);
    step(1, 0, 0, CALL, 32'h60, '0, '0, 0);
    step(1, 0, 0, CALL, 32'h70, '0, '0, 0);
    settle();
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("async rst pc_out", bus.pc_out, 32'h0);
    chk("async rst ras_empty", 32'(bus.ras_empty), 32'd1);
    chk("async rst ras_full", 32'(bus.ras_full), 32'd0);
`ifdef PC_PREV_EN
    chk("async rst pc_prev", bus.pc_prev, 32'h0);
`endif
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      src = 3'($urandom_range(0, 7));
      step(1, 0, 0, src, $urandom, $urandom, $urandom, 0);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised program-counter unit for the multi-cycle datapath. Successor to the fixed 32-bit, unit-step PC.
- Adds:
  - configurable address width, increment step and reset vector;
  - conditional-branch write enable (pc_write_cond & zero);
  - CALL/RET sources backed by an internal return-address stack (RAS) of configurable depth, with full/empty status and sticky error flags.
- Sits between the control FSM and the instruction-memory address port.

Parameters:
- ADDR_W, 32, width of the PC, all address inputs and RAS entries.
- STEP, 1, increment added for sequential fetch and for the CALL return address.
- RESET_VEC, 0, value loaded into pc_out on reset.
- RAS_DEPTH, 4, number of RAS entries; must be ≥2 and a power of two.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- pc_write  in  1  unconditional PC update enable.
- pc_write_cond  in  1  update enable gated by zero.
- zero  in  1  ALU zero flag.
- pc_source  in  3  next-PC select: 0 INC, 1 BRANCH, 2 JUMP, 3 ALU, 4 CALL, 5 RET, 6/7 reserved.
- jump_address  in  ADDR_W  jump/call target.
- alu_out_result  in  ADDR_W  registered ALU output (branch target).
- alu_result  in  ADDR_W  combinational ALU result.
- clr_err  in  1  clears the sticky error flags.
- pc_out  out  ADDR_W  current PC.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_empty  out  1  RAS holds 0 entries.
- ras_overflow  out  1  sticky: a push occurred while the RAS was full.
- ras_underflow  out  1  sticky: a pop occurred while the RAS was empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc_out = RESET_VEC.
  - RAS count = 0, top pointer = 0; ras_empty = 1, ras_full = 0.
  - Sticky flags = 0.
  - Reset asserted mid-operation discards any pending update; the RAS contents are don't-care.
- Update enable: en = pc_write | (pc_write_cond & zero), evaluated each rising edge. When en = 0, pc_out and the RAS hold.
- When en = 1, next pc_out by source:
  - INC: pc_out + STEP.
  - BRANCH: alu_out_result.
  - JUMP: jump_address.
  - ALU: alu_result.
  - CALL: jump_address. In the same edge, push pc_out + STEP.
  - RET: top-of-stack. In the same edge, pop.
  - 6/7: alu_result (matches the legacy default arm). No RAS effect.
- Arithmetic: all additions are modulo 2^ADDR_W. Wrap from the all-ones address to 0 is legal and raises no flag.
- Latency: one cycle, registered. pc_out, ras_full and ras_empty are register-derived; no combinational path from inputs to outputs.
- RAS organisation:
  - Circular buffer with a top pointer and a count in 0..RAS_DEPTH.
  - Push writes entry [top+1] and advances top.
  - Pop reads entry [top] and retreats top.
- Push when full:
  - overwrite the oldest entry (the buffer wraps);
  - count stays at RAS_DEPTH;
  - ras_overflow is set.
- Pop when empty:
  - pc_out <= pc_out + STEP (fall through);
  - count stays 0;
  - ras_underflow is set.
- Sticky flags:
  - Cleared by clr_err = 1 at a rising edge.
  - If the same edge also sets a flag, set wins.
- The RAS is updated only when en = 1 and pc_source is CALL or RET. A CALL/RET suppressed by pc_write_cond & !zero has no effect.

Optional Feature:
- Macro PC_PREV_EN.
- Defined: adds output pc_prev (ADDR_W).
  - Reset value RESET_VEC.
  - Loaded with the old pc_out on every edge where en = 1, for use as an exception PC.
- Undefined: port absent, no register, behaviour otherwise identical.

Decomposition:
- Shared package pc_pkg:
  - enum pc_src_t (INC=0, BRANCH=1, JUMP=2, ALU=3, CALL=4, RET=5);
  - localparam PC_SRC_W=3.
- Sub-module ras_stack (params DEPTH, W):
  - inputs push, pop, push_data;
  - outputs top_data, full, empty, ovf_pulse, unf_pulse.
- pc_unit_ras owns the next-PC mux, the enable logic and the sticky flags.

Test Plan:
- Reset/INC: release rst_n with STEP=1, RESET_VEC=0; pulse pc_write + INC three times → pc_out 1, 2, 3; ras_empty=1.
- Cond branch: pc_write_cond=1, BRANCH, alu_out_result=0x40:
  - zero=0 → pc_out unchanged;
  - zero=1 → pc_out=0x40 next cycle.
- Call/return nesting, pc=0x10:
  - CALL 0x100 → pc_out=0x100;
  - CALL 0x200 → pc_out=0x200;
  - RET → 0x101;
  - RET → 0x11;
  - ras_empty=1 after the second RET.
- Overflow, RAS_DEPTH=4:
  - five CALLs from pcs 0..4 → ras_full=1, ras_overflow=1;
  - four RETs return 5, 4, 3, 2; the oldest return (1) is lost.
- Underflow and clear:
  - RET on empty at pc=0x20 → pc_out=0x21, ras_underflow=1;
  - clr_err → flag 0;
  - clr_err on the same edge as a new underflow → flag stays 1.
- Async reset mid-stack: after two CALLs, drop rst_n between edges → pc_out=RESET_VEC immediately, ras_empty=1; with PC_PREV_EN, pc_prev=RESET_VEC.
